// File: rtl/zion_basic_circuit_lib_clr_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush; all outputs registered.
// Optional stall counter enabled by defining ZION_CLR_SKID_BUF_STALL_CNT_EN.
module zion_basic_circuit_lib_clr_skid_buf #(
    parameter int unsigned            WIDTH_IN  = 8,
    parameter int unsigned            WIDTH_OUT = 8,
    parameter logic [WIDTH_OUT-1:0]   INI_DATA  = '0,
    parameter int unsigned            CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iClr,
    input  logic                 iVld,
    output logic                 oRdy,
    input  logic [WIDTH_IN-1:0]  iDat,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic [WIDTH_OUT-1:0] oDat
`ifdef ZION_CLR_SKID_BUF_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] oStallCnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH_OUT-1:0] skid;

    // Width mismatch is an integration error caught at elaboration.
    if (WIDTH_IN != WIDTH_OUT) begin : g_width_err
        $error("zion_basic_circuit_lib_clr_skid_buf: WIDTH_IN (%0d) != WIDTH_OUT (%0d)",
               WIDTH_IN, WIDTH_OUT);
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_basic_circuit_lib_clr_skid_buf: exiting on parameter error");
`endif
    end

    // Buffer state machine; oVld/oRdy are kept as flops alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            oVld  <= 1'b0;
            oRdy  <= 1'b1;
            oDat  <= INI_DATA;
            skid  <= INI_DATA;
        end else if (iClr) begin
            state <= EMPTY;
            oVld  <= 1'b0;
            oRdy  <= 1'b1;
            oDat  <= INI_DATA;
            skid  <= INI_DATA;
        end else begin
            case (state)
                EMPTY: begin
                    if (iVld) begin
                        oDat  <= WIDTH_OUT'(iDat);
                        state <= ONE;
                        oVld  <= 1'b1;
                        oRdy  <= 1'b1;
                    end
                end
                ONE: begin
                    if (iVld && iRdy) begin
                        oDat <= WIDTH_OUT'(iDat);
                    end else if (iVld) begin
                        skid  <= WIDTH_OUT'(iDat);
                        state <= FULL;
                        oVld  <= 1'b1;
                        oRdy  <= 1'b0;
                    end else if (iRdy) begin
                        state <= EMPTY;
                        oVld  <= 1'b0;
                        oRdy  <= 1'b1;
                    end
                end
                FULL: begin
                    if (iRdy) begin
                        oDat  <= skid;
                        state <= ONE;
                        oVld  <= 1'b1;
                        oRdy  <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    oVld  <= 1'b0;
                    oRdy  <= 1'b1;
                end
            endcase
        end
    end

`ifdef ZION_CLR_SKID_BUF_STALL_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Saturating count of cycles where valid output is held off by the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oStallCnt <= '0;
        end else if (iClr) begin
            oStallCnt <= '0;
        end else if (oVld && !iRdy && (oStallCnt != CNT_MAX)) begin
            oStallCnt <= oStallCnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
